// File: rtl/board_access_sched.sv
// board_access_sched: owner of the single board BRAM port and game sequencer.
//   The renderer drives the port during active video with no added latency.
//   During vertical blank (render_done_in high) the port is lent to the
//   generation-update engine. New generations start every FRAMES_PER_GEN
//   frames while run_in is high, or once per step_in request.
// Ports:
//   clk_130mhz, rst_n_in            clock, async active-low reset
//   render_done_in, render_addr_in  renderer blank flag and read address
//   run_in, step_in                 free-run level, single-step pulse
//   gen_start_out, upd_done_in      generation start / finish handshake
//   upd_req_in/we/addr/wdata        update engine access request
//   upd_gnt_out                     access accepted this cycle (combinational)
//   upd_rvalid_out, upd_rdata_out   read return to the update engine
//   mem_addr/we/wdata_out, mem_rdata_in  BRAM port
//   gen_count_out, busy_out         completed generations, generation active
module board_access_sched #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned READ_LAT       = 2,
    parameter int unsigned FRAMES_PER_GEN = 8
) (
    input  logic              clk_130mhz,
    input  logic              rst_n_in,
    input  logic              render_done_in,
    input  logic [ADDR_W-1:0] render_addr_in,
    input  logic              run_in,
    input  logic              step_in,
    output logic              gen_start_out,
    input  logic              upd_done_in,
    input  logic              upd_req_in,
    input  logic              upd_we_in,
    input  logic [ADDR_W-1:0] upd_addr_in,
    input  logic [DATA_W-1:0] upd_wdata_in,
    output logic              upd_gnt_out,
    output logic              upd_rvalid_out,
    output logic [DATA_W-1:0] upd_rdata_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic [15:0]       gen_count_out,
    output logic              busy_out
);

    localparam int unsigned FC_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {
        S_RENDER,
        S_BLANK,
        S_UPDATE,
        S_SUSPEND
    } state_t;

    state_t            state, state_nxt;
    logic              done_q;
    logic              tick;
    logic [FC_W-1:0]   frame_cnt, frame_cnt_nxt;
    logic              step_pending, step_pending_nxt;
    logic              start, finish;
    logic              rd_fire;
    logic              rv_next;
    logic [READ_LAT-1:0] rd_pipe;

    // Frame tick on the rising edge of the renderer blank flag
    assign tick = render_done_in & ~done_q;

    // Port mux: grant drops in the same cycle blank ends, renderer never waits
    assign upd_gnt_out   = upd_req_in & (state == S_UPDATE) & render_done_in;
    assign mem_addr_out  = upd_gnt_out ? upd_addr_in : render_addr_in;
    assign mem_we_out    = upd_gnt_out & upd_we_in;
    assign mem_wdata_out = upd_wdata_in;
    assign rd_fire       = upd_gnt_out & ~upd_we_in;

    // Valid pipe tail; rdata is captured on the edge that raises rvalid
    assign upd_rvalid_out = rd_pipe[READ_LAT-1];
    generate
        if (READ_LAT == 1) begin : g_rv1
            assign rv_next = rd_fire;
        end else begin : g_rvn
            assign rv_next = rd_pipe[READ_LAT-2];
        end
    endgenerate

    // Next-state and sequencing decisions
    always_comb begin
        state_nxt        = state;
        start            = 1'b0;
        finish           = 1'b0;
        frame_cnt_nxt    = frame_cnt;
        step_pending_nxt = step_pending | step_in;

        case (state)
            S_RENDER: begin
                if (tick) begin
                    if (step_pending | (run_in & (frame_cnt == FC_LAST))) begin
                        start     = 1'b1;
                        state_nxt = S_UPDATE;
                    end else begin
                        state_nxt = S_BLANK;
                    end
                end
            end
            S_BLANK: begin
                if (!render_done_in) state_nxt = S_RENDER;
            end
            S_UPDATE, S_SUSPEND: begin
                if (upd_done_in) begin
                    finish    = 1'b1;
                    state_nxt = render_done_in ? S_BLANK : S_RENDER;
                end else if ((state == S_UPDATE) && !render_done_in) begin
                    state_nxt = S_SUSPEND;
                end else if ((state == S_SUSPEND) && tick) begin
                    state_nxt = S_UPDATE;
                end
            end
            default: state_nxt = S_RENDER;
        endcase

        // Frames are counted only on ticks seen in S_RENDER; resume ticks do not count
        if (!run_in || start) begin
            frame_cnt_nxt = '0;
        end else if (tick && (state == S_RENDER)) begin
            frame_cnt_nxt = frame_cnt + FC_W'(1);
        end

        // A step arriving with a start is absorbed into that start
        if (start) step_pending_nxt = 1'b0;
    end

    // State and registered outputs
    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_RENDER;
            done_q        <= 1'b0;
            frame_cnt     <= '0;
            step_pending  <= 1'b0;
            gen_start_out <= 1'b0;
            busy_out      <= 1'b0;
            gen_count_out <= '0;
            rd_pipe       <= '0;
            upd_rdata_out <= '0;
        end else begin
            state         <= state_nxt;
            done_q        <= render_done_in;
            frame_cnt     <= frame_cnt_nxt;
            step_pending  <= step_pending_nxt;
            gen_start_out <= start;
            if (start) begin
                busy_out <= 1'b1;
            end else if (finish) begin
                busy_out <= 1'b0;
            end
            if (finish) gen_count_out <= gen_count_out + 16'd1;
            rd_pipe[0] <= rd_fire;
            for (int i = 1; i < int'(READ_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
            if (rv_next) upd_rdata_out <= mem_rdata_in;
        end
    end

endmodule
